// File: rtl/fpu_issue_collect.sv
// Issue/collect shell for a fixed-latency pipelined FPU unit.
// Requests are registered onto the unit's operand inputs, a valid/tag shadow
// pipeline tracks them to the unit's output, and results are queued in a
// show-ahead FIFO. Credit (in-flight + queued < DEPTH) guarantees that every
// result has a FIFO slot waiting for it.
module fpu_issue_collect #(
  parameter int NSTAGE = 2,
  parameter int DEPTH  = 4,
  parameter int TAGW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_x1,
  input  logic [31:0]     req_x2,
  input  logic [TAGW-1:0] req_tag,
  output logic [31:0]     fpu_x1,
  output logic [31:0]     fpu_x2,
  input  logic [31:0]     fpu_y,
  input  logic            fpu_ovf,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_y,
  output logic            res_ovf,
  output logic [TAGW-1:0] res_tag,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(NSTAGE + DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]     r_x1_p0;
  logic [31:0]     r_x2_p0;
  logic [NSTAGE-1:0] r_vld;
  logic [TAGW-1:0] r_tag [NSTAGE];

  logic [31:0]     r_mem_y   [DEPTH];
  logic            r_mem_ovf [DEPTH];
  logic [TAGW-1:0] r_mem_tag [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_count;

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic [SW-1:0]   w_inflight;

  assign w_empty   = (r_count == '0);
  assign res_valid = ~w_empty;
  assign w_accept  = req_valid & req_ready;
  assign w_push    = r_vld[NSTAGE-1];
  assign w_pop     = res_valid & res_ready;

  // Count ops still travelling through the unit (popcount of shadow valids).
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      w_inflight = w_inflight + SW'(r_vld[k]);
    end
  end

  assign req_ready = (w_inflight + SW'(r_count)) < SW'(DEPTH);
  assign busy      = (w_inflight != '0) | (r_count != '0);

  // Head of queue; reads zero while the FIFO is empty.
  assign res_y   = w_empty ? '0 : r_mem_y[r_rd];
  assign res_ovf = w_empty ? 1'b0 : r_mem_ovf[r_rd];
  assign res_tag = w_empty ? '0 : r_mem_tag[r_rd];

  assign fpu_x1 = r_x1_p0;
  assign fpu_x2 = r_x2_p0;

  // Operand register feeding the unit; holds its value when nothing is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x1_p0 <= '0;
      r_x2_p0 <= '0;
    end else if (w_accept) begin
      r_x1_p0 <= req_x1;
      r_x2_p0 <= req_x2;
    end
  end

  // Shadow pipeline: valid and tag advance one stage per edge alongside the unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_vld[0] <= w_accept;
      r_tag[0] <= req_tag;
      for (int k = 1; k < NSTAGE; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // Result storage written when the last shadow stage is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_y[r_wr]   <= fpu_y;
      r_mem_ovf[r_wr] <= fpu_ovf;
      r_mem_tag[r_wr] <= r_tag[NSTAGE-1];
    end
  end

  // FIFO pointers and occupancy; pointers wrap by compare-and-reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_collect.sv
// Directed bench for fpu_issue_collect (NSTAGE=2, DEPTH=4, TAGW=4) driving a
// stub FPU with one register stage after the DUT's operand register.
module tb_fpu_issue_collect;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_x1;
  logic [31:0] req_x2;
  logic [3:0]  req_tag;
  logic [31:0] fpu_x1;
  logic [31:0] fpu_x2;
  logic [31:0] fpu_y;
  logic        fpu_ovf;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_y;
  logic        res_ovf;
  logic [3:0]  res_tag;
  logic        busy;

  int n_chk;
  int n_fail;

  fpu_issue_collect #(.NSTAGE(2), .DEPTH(4), .TAGW(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
    .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y), .fpu_ovf(fpu_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_ovf(res_ovf), .res_tag(res_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub fsub: exact answers for the two IEEE vectors used, otherwise x1^x2 as an opaque token.
  function automatic logic [32:0] stub(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4040_0000 && b == 32'h3F80_0000) return {1'b0, 32'h4000_0000};
    if (a == 32'h7F7F_FFFF && b == 32'hFF7F_FFFF) return {1'b1, 32'h7F80_0000};
    return {1'b0, a ^ b};
  endfunction

  // Second pipeline stage of the stub unit; not reset, keeps producing values.
  always @(posedge clk) {fpu_ovf, fpu_y} <= stub(fpu_x1, fpu_x2);

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sx1(input int i);
    return 32'h3F80_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] sx2(input int i);
    return 32'h0000_0001 << i;
  endfunction

  initial begin
    int n_acc;
    logic [32:0] e;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_x1 = '0;
    req_x2 = '0;
    req_tag = '0;
    res_ready = 1'b0;
    #12 rst = 1'b0;
    tick();

    // Reset state
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_fpu_x1", fpu_x1, 32'd0);
    chk("rst_res_y", res_y, 32'd0);
    chk("rst_res_tag", 32'(res_tag), 32'd0);

    // Single op: 3.0 - 1.0 = 2.0, tag 5
    req_valid = 1'b1; req_x1 = 32'h4040_0000; req_x2 = 32'h3F80_0000; req_tag = 4'd5;
    chk("single_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("single_fpu_x1", fpu_x1, 32'h4040_0000);
    chk("single_fpu_x2", fpu_x2, 32'h3F80_0000);
    chk("single_valid_e0", 32'(res_valid), 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    tick();
    chk("single_valid_e1", 32'(res_valid), 32'd0);
    tick();
    chk("single_valid_e2", 32'(res_valid), 32'd1);
    chk("single_y", res_y, 32'h4000_0000);
    chk("single_ovf", 32'(res_ovf), 32'd0);
    chk("single_tag", 32'(res_tag), 32'd5);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("single_valid_after_pop", 32'(res_valid), 32'd0);
    chk("single_busy_after_pop", 32'(busy), 32'd0);

    // Overflow passthrough, then asynchronous reset mid-cycle with a result queued
    req_valid = 1'b1; req_x1 = 32'h7F7F_FFFF; req_x2 = 32'hFF7F_FFFF; req_tag = 4'd9;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("ovf_valid", 32'(res_valid), 32'd1);
    chk("ovf_y", res_y, 32'h7F80_0000);
    chk("ovf_flag", 32'(res_ovf), 32'd1);
    chk("ovf_tag", 32'(res_tag), 32'd9);
    #4 rst = 1'b1;
    #1;
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_fpu_x1", fpu_x1, 32'd0);
    chk("arst_fpu_x2", fpu_x2, 32'd0);
    chk("arst_res_y", res_y, 32'd0);
    chk("arst_res_ovf", 32'(res_ovf), 32'd0);
    #2 rst = 1'b0;
    tick();

    // Streaming: 8 back-to-back ops, consumer always ready
    res_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        req_valid = 1'b1; req_x1 = sx1(c); req_x2 = sx2(c); req_tag = 4'(c);
        chk("stream_ready", 32'(req_ready), 32'd1);
      end else begin
        req_valid = 1'b0;
      end
      if (c >= 3 && c <= 10) begin
        e = stub(sx1(c - 3), sx2(c - 3));
        chk("stream_valid", 32'(res_valid), 32'd1);
        chk("stream_tag", 32'(res_tag), 32'(c - 3));
        chk("stream_y", res_y, e[31:0]);
      end else begin
        chk("stream_idle", 32'(res_valid), 32'd0);
      end
      tick();
    end
    chk("stream_busy_end", 32'(busy), 32'd0);

    // Backpressure: consumer stalled, producer always valid
    res_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1; req_x1 = sx1(16 + n_acc); req_x2 = sx2(n_acc); req_tag = 4'(n_acc);
      if (req_ready) n_acc++;
      tick();
    end
    chk("bp_accepts", 32'(n_acc), 32'd4);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = stub(sx1(16 + i), sx2(i));
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_tag", 32'(res_tag), 32'(i));
      chk("bp_y", res_y, e[31:0]);
      if (i == 0) chk("bp_ready_before_pop", 32'(req_ready), 32'd0);
      tick();
      chk("bp_ready_after_pop", 32'(req_ready), 32'd1);
    end
    chk("bp_drained", 32'(res_valid), 32'd0);
    chk("bp_busy", 32'(busy), 32'd0);

    // Reset mid-operation: two ops in flight, stub keeps driving y
    res_ready = 1'b0;
    req_valid = 1'b1; req_x1 = 32'h1111_1111; req_x2 = 32'h2222_2222; req_tag = 4'd1;
    tick();
    req_x1 = 32'h3333_3333; req_tag = 4'd2;
    tick();
    req_valid = 1'b0;
    chk("mid_busy_before", 32'(busy), 32'd1);
    #4 rst = 1'b1;
    #10 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("mid_no_result", 32'(res_valid), 32'd0);
    end
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
